inst_buffer: RTL and testbench

Dual-ported instruction queue between the fetch stage and decode. Accepts up to two fetched instructions per cycle with their prediction info, exception code and RAS snapshot. Presents the oldest one or two entries to decode in program order. Decode registers them; the queue pops them on any cycle where decode is not busy. A flush from commit empties the queue.

---
 rtl/inst_buffer.sv | 115 +++++++++++
 tb/tb_inst_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
// Circular fetch-to-decode queue: up to two pushes and two pops per cycle, one-cycle push-to-output latency.
// Backpressure: buffer_full (count >= DEPTH-1) makes fetch hold; decode_busy freezes the head.
module inst_buffer #(
    parameter int DEPTH = 16,
    parameter int EXC_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             fetch_valid0,
    input  logic             fetch_valid1,
    input  logic [31:0]      fetch_PC0,
    input  logic [31:0]      fetch_PC1,
    input  logic [31:0]      fetch_inst0,
    input  logic [31:0]      fetch_inst1,
    input  logic             fetch_predict0,
    input  logic             fetch_predict1,
    input  logic [31:0]      fetch_predict_target0,
    input  logic [31:0]      fetch_predict_target1,
    input  logic [EXC_W-1:0] fetch_excode0,
    input  logic [EXC_W-1:0] fetch_excode1,
    input  logic [63:0]      fetch_RAS,
    output logic             buffer_full,
    output logic             buffer_valid0,
    output logic             buffer_valid1,
    output logic [31:0]      buffer_PC0,
    output logic [31:0]      buffer_PC1,
    output logic [31:0]      buffer_inst0,
    output logic [31:0]      buffer_inst1,
    output logic             buffer_predict0,
    output logic             buffer_predict1,
    output logic [31:0]      buffer_predict_target0,
    output logic [31:0]      buffer_predict_target1,
    output logic [EXC_W-1:0] buffer_excode0,
    output logic [EXC_W-1:0] buffer_excode1,
    output logic [63:0]      buffer_RAS,
    input  logic             decode_busy
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic             predict;
        logic [31:0]      target;
        logic [EXC_W-1:0] excode;
        logic [63:0]      ras;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;

    entry_t     wr0;
    entry_t     wr1;
    entry_t     rd0;
    entry_t     rd1;
    logic       push_en;
    logic [1:0] push_n;
    logic [1:0] pop_n;

    assign buffer_full   = count >= (AW+1)'(DEPTH - 1);
    assign buffer_valid0 = count != '0;
    assign buffer_valid1 = count >= (AW+1)'(2);

    assign push_en = ~flush & ~buffer_full;
    assign push_n  = push_en ? ({1'b0, fetch_valid0} + {1'b0, fetch_valid1}) : 2'd0;
    assign pop_n   = (~flush & ~decode_busy) ? ({1'b0, buffer_valid0} + {1'b0, buffer_valid1}) : 2'd0;

    assign wr0 = '{pc: fetch_PC0, inst: fetch_inst0, predict: fetch_predict0,
                   target: fetch_predict_target0, excode: fetch_excode0, ras: fetch_RAS};
    assign wr1 = '{pc: fetch_PC1, inst: fetch_inst1, predict: fetch_predict1,
                   target: fetch_predict_target1, excode: fetch_excode1, ras: fetch_RAS};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop_n);
            tail  <= tail + AW'(push_n);
            count <= count + (AW+1)'(push_n) - (AW+1)'(pop_n);
        end
    end

    // A lone valid slot (either one) is compacted into tail.
    always_ff @(posedge clk) begin
        if (push_en && (fetch_valid0 || fetch_valid1))
            mem[tail] <= fetch_valid0 ? wr0 : wr1;
        if (push_en && fetch_valid0 && fetch_valid1)
            mem[tail + AW'(1)] <= wr1;
    end

    always_comb begin
        rd0 = buffer_valid0 ? mem[head] : '0;
        rd1 = buffer_valid1 ? mem[head + AW'(1)] : '0;
        buffer_PC0             = rd0.pc;
        buffer_inst0           = rd0.inst;
        buffer_predict0        = rd0.predict;
        buffer_predict_target0 = rd0.target;
        buffer_excode0         = rd0.excode;
        buffer_RAS             = rd0.ras;
        buffer_PC1             = rd1.pc;
        buffer_inst1           = rd1.inst;
        buffer_predict1        = rd1.predict;
        buffer_predict_target1 = rd1.target;
        buffer_excode1         = rd1.excode;
    end
endmodule

// File: tb/tb_inst_buffer.sv
// Randomized and directed stimulus for inst_buffer, checked against a queue-based reference model.
module tb_inst_buffer;
    localparam int DEPTH = 16;
    localparam int EXC_W = 5;

    logic             clk = 1'b0;
    logic             resetn, flush, decode_busy;
    logic             fetch_valid0, fetch_valid1, fetch_predict0, fetch_predict1;
    logic [31:0]      fetch_PC0, fetch_PC1, fetch_inst0, fetch_inst1;
    logic [31:0]      fetch_predict_target0, fetch_predict_target1;
    logic [EXC_W-1:0] fetch_excode0, fetch_excode1;
    logic [63:0]      fetch_RAS;
    logic             buffer_full, buffer_valid0, buffer_valid1, buffer_predict0, buffer_predict1;
    logic [31:0]      buffer_PC0, buffer_PC1, buffer_inst0, buffer_inst1;
    logic [31:0]      buffer_predict_target0, buffer_predict_target1;
    logic [EXC_W-1:0] buffer_excode0, buffer_excode1;
    logic [63:0]      buffer_RAS;

    inst_buffer #(.DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .fetch_valid0(fetch_valid0), .fetch_valid1(fetch_valid1),
        .fetch_PC0(fetch_PC0), .fetch_PC1(fetch_PC1),
        .fetch_inst0(fetch_inst0), .fetch_inst1(fetch_inst1),
        .fetch_predict0(fetch_predict0), .fetch_predict1(fetch_predict1),
        .fetch_predict_target0(fetch_predict_target0), .fetch_predict_target1(fetch_predict_target1),
        .fetch_excode0(fetch_excode0), .fetch_excode1(fetch_excode1),
        .fetch_RAS(fetch_RAS), .buffer_full(buffer_full),
        .buffer_valid0(buffer_valid0), .buffer_valid1(buffer_valid1),
        .buffer_PC0(buffer_PC0), .buffer_PC1(buffer_PC1),
        .buffer_inst0(buffer_inst0), .buffer_inst1(buffer_inst1),
        .buffer_predict0(buffer_predict0), .buffer_predict1(buffer_predict1),
        .buffer_predict_target0(buffer_predict_target0), .buffer_predict_target1(buffer_predict_target1),
        .buffer_excode0(buffer_excode0), .buffer_excode1(buffer_excode1),
        .buffer_RAS(buffer_RAS), .decode_busy(decode_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic             pred;
        logic [31:0]      tgt;
        logic [EXC_W-1:0] exc;
        logic [63:0]      ras;
    } ent_t;

    ent_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs();
        ent_t z = '{default: '0};
        ent_t e0, e1;
        e0 = (q.size() >= 1) ? q[0] : z;
        e1 = (q.size() >= 2) ? q[1] : z;
        check("full",    64'(buffer_full),   64'(q.size() >= DEPTH - 1));
        check("valid0",  64'(buffer_valid0), 64'(q.size() >= 1));
        check("valid1",  64'(buffer_valid1), 64'(q.size() >= 2));
        check("pc0",     64'(buffer_PC0),    64'(e0.pc));
        check("pc1",     64'(buffer_PC1),    64'(e1.pc));
        check("inst0",   64'(buffer_inst0),  64'(e0.inst));
        check("inst1",   64'(buffer_inst1),  64'(e1.inst));
        check("pred0",   64'(buffer_predict0), 64'(e0.pred));
        check("pred1",   64'(buffer_predict1), 64'(e1.pred));
        check("tgt0",    64'(buffer_predict_target0), 64'(e0.tgt));
        check("tgt1",    64'(buffer_predict_target1), 64'(e1.tgt));
        check("exc0",    64'(buffer_excode0), 64'(e0.exc));
        check("exc1",    64'(buffer_excode1), 64'(e1.exc));
        check("ras",     buffer_RAS, e0.ras);
    endtask

    // Queue semantics: pop up to two from the front, then append valid slots if there was room before the pop.
    task automatic model_update();
        ent_t s0, s1;
        bit   room;
        int   n;
        s0 = '{pc: fetch_PC0, inst: fetch_inst0, pred: fetch_predict0, tgt: fetch_predict_target0,
               exc: fetch_excode0, ras: fetch_RAS};
        s1 = '{pc: fetch_PC1, inst: fetch_inst1, pred: fetch_predict1, tgt: fetch_predict_target1,
               exc: fetch_excode1, ras: fetch_RAS};
        if (!resetn || flush) begin
            q.delete();
        end else begin
            room = q.size() < DEPTH - 1;
            if (!decode_busy) begin
                n = (q.size() > 2) ? 2 : q.size();
                repeat (n) void'(q.pop_front());
            end
            if (room) begin
                if (fetch_valid0) q.push_back(s0);
                if (fetch_valid1) q.push_back(s1);
            end
        end
    endtask

    task automatic tick();
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic v0, input logic v1, input logic [31:0] pc0, input logic [31:0] pc1);
        fetch_valid0          = v0;
        fetch_valid1          = v1;
        fetch_PC0             = pc0;
        fetch_PC1             = pc1;
        fetch_inst0           = $urandom;
        fetch_inst1           = $urandom;
        fetch_predict0        = 1'($urandom);
        fetch_predict1        = 1'($urandom);
        fetch_predict_target0 = $urandom;
        fetch_predict_target1 = $urandom;
        fetch_excode0         = EXC_W'($urandom);
        fetch_excode1         = EXC_W'($urandom);
        fetch_RAS             = {$urandom, $urandom};
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            drive(1'b0, 1'b0, $urandom, $urandom);
            tick();
        end
    endtask

    initial begin
        resetn = 1'b0;
        flush = 1'b0;
        decode_busy = 1'b0;
        drive(1'b1, 1'b1, 32'h10, 32'h14);
        // State is unknown until the first reset edge, so only the model is cleared here.
        @(posedge clk); model_update(); #1;
        tick();
        resetn = 1'b1;

        // Hold then release
        decode_busy = 1'b1;
        drive(1'b1, 1'b1, 32'h1000, 32'h1004);
        tick();
        idle(5);
        decode_busy = 1'b0;
        idle(2);

        // Fill to the full threshold, then an ignored pair, then drain
        decode_busy = 1'b1;
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 1'b1, 32'h4000 + 32'(16 * k), 32'h4008 + 32'(16 * k));
            tick();
        end
        drive(1'b1, 1'b0, 32'h4100, 32'h0);
        tick();
        drive(1'b1, 1'b1, 32'h4200, 32'h4204);
        tick();
        decode_busy = 1'b0;
        idle(10);

        // Wrap with continuous streaming
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b1, 32'h2000 + 32'(8 * k), 32'h2004 + 32'(8 * k));
            tick();
        end
        idle(2);

        // Slot1-only compaction, then a pair
        drive(1'b0, 1'b1, 32'h0, 32'h3004);
        tick();
        drive(1'b1, 1'b1, 32'h3008, 32'h300C);
        tick();
        idle(3);

        // Flush with a simultaneous push
        decode_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 32'h5000 + 32'(8 * k), 32'h5004 + 32'(8 * k));
            tick();
        end
        decode_busy = 1'b0;
        flush = 1'b1;
        drive(1'b1, 1'b1, 32'h5100, 32'h5104);
        tick();
        flush = 1'b0;
        drive(1'b1, 1'b1, 32'h5200, 32'h5204);
        tick();
        idle(2);

        // Random traffic, busy-biased so the queue fills and wraps repeatedly
        for (int k = 0; k < 600; k++) begin
            decode_busy = ($urandom_range(0, 99) < 55);
            flush       = ($urandom_range(0, 63) == 0);
            resetn      = ($urandom_range(0, 199) != 0);
            drive(1'($urandom), 1'($urandom), $urandom, $urandom);
            tick();
        end
        resetn = 1'b1;
        flush = 1'b0;
        decode_busy = 1'b0;
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
